// File: rtl/rvc_pkg.sv
// Shared constants, FSM encoding and length decode for the RVC fetch aligner.
package rvc_pkg;

    localparam int HALFWORD_W = 16;
    localparam int BUF_DEPTH  = 3;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_STALE = 2'd2
    } fsm_t;

    // A halfword whose low two bits are not 2'b11 starts a compressed instruction.
    function automatic logic is_rvc(input logic [HALFWORD_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/rvc_halfword_buffer.sv
// Three-entry halfword shift buffer: pop 0..2 from the head, then append 0..2 behind what remains.
module rvc_halfword_buffer
    import rvc_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                clear,
    input  logic [1:0]                          pop_n,
    input  logic [1:0]                          push_n,
    input  logic [2*HALFWORD_W-1:0]             push_data,
    output logic [1:0][HALFWORD_W-1:0]          head,
    output logic [1:0]                          count
);

    logic [BUF_DEPTH-1:0][HALFWORD_W-1:0] entries, shifted, entries_nxt;
    logic [1:0] base;

    assign head = entries[1:0];
    assign base = count - pop_n;

    always_comb begin
        shifted     = entries >> (HALFWORD_W * int'(pop_n));
        entries_nxt = shifted;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (push_n != 2'd0 && i == int'(base))
                entries_nxt[i] = push_data[HALFWORD_W-1:0];
            if (push_n == 2'd2 && i == int'(base) + 1)
                entries_nxt[i] = push_data[2*HALFWORD_W-1:HALFWORD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entries <= '0;
            count   <= 2'd0;
        end else if (clear) begin
            count   <= 2'd0;
        end else begin
            entries <= entries_nxt;
            count   <= base + push_n;
        end
    end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetches aligned IMEM words and hands out 16/32-bit instructions with their PC.
// Optional statistics counters are enabled by defining RVC_ALIGNER_STATS_EN.
module rvc_fetch_aligner
    import rvc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_req_valid,
    output logic [XLEN-1:0] fetch_req_addr,
    input  logic            fetch_req_ready,
    input  logic            fetch_resp_valid,
    input  logic [31:0]     fetch_resp_data,
    output logic            instr_valid,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_compressed,
    input  logic            instr_ready
`ifdef RVC_ALIGNER_STATS_EN
    ,
    output logic [31:0]     stat_c_count,
    output logic [31:0]     stat_i_count
`endif
);

    fsm_t state, state_nxt;
    logic [XLEN-1:0] fetch_pc, head_pc;
    logic            skip_lo;
    logic [1:0][HALFWORD_W-1:0] head;
    logic [1:0]      count, needed, pop_n, push_n, count_after_pop;
    logic            head_rvc, accept, req_fire, resp_take;
    logic [31:0]     push_data;

    assign head_rvc         = is_rvc(head[0]);
    assign needed           = head_rvc ? 2'd1 : 2'd2;
    assign instr_valid      = count >= needed;
    assign instr_data       = !instr_valid ? 32'h0 :
                              head_rvc     ? {16'h0, head[0]} : {head[1], head[0]};
    assign instr_compressed = instr_valid & head_rvc;
    assign instr_pc         = head_pc;

    assign accept          = instr_valid & instr_ready;
    assign pop_n           = accept ? needed : 2'd0;
    assign count_after_pop = count - pop_n;

    // Request only when a full word is guaranteed to fit after this cycle's pop.
    assign fetch_req_valid = reset_n && state == S_REQ && count_after_pop <= 2'd1;
    assign fetch_req_addr  = fetch_pc;
    assign req_fire        = fetch_req_valid & fetch_req_ready;

    assign resp_take = state == S_WAIT && fetch_resp_valid && !redirect_valid;
    assign push_n    = !resp_take ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
    assign push_data = skip_lo ? {16'h0, fetch_resp_data[31:16]} : fetch_resp_data;

    rvc_halfword_buffer u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (redirect_valid),
        .pop_n     (pop_n),
        .push_n    (push_n),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            // Any response still owed by IMEM belongs to the old stream.
            if (state == S_REQ) state_nxt = req_fire ? S_STALE : S_REQ;
            else                state_nxt = fetch_resp_valid ? S_REQ : S_STALE;
        end else begin
            case (state)
                S_REQ:           if (req_fire) state_nxt = S_WAIT;
                S_WAIT, S_STALE: if (fetch_resp_valid) state_nxt = S_REQ;
                default:         state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_REQ;
            fetch_pc <= RESET_VECTOR & ~XLEN'(3);
            skip_lo  <= RESET_VECTOR[1];
            head_pc  <= RESET_VECTOR & ~XLEN'(1);
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                skip_lo  <= redirect_pc[1];
                head_pc  <= redirect_pc & ~XLEN'(1);
            end else begin
                if (resp_take) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    skip_lo  <= 1'b0;
                end
                if (accept)
                    head_pc <= head_pc + (head_rvc ? XLEN'(2) : XLEN'(4));
            end
        end
    end

`ifdef RVC_ALIGNER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_c_count <= 32'h0;
            stat_i_count <= 32'h0;
        end else if (accept) begin
            if (head_rvc && stat_c_count != 32'hffff_ffff)
                stat_c_count <= stat_c_count + 32'h1;
            if (!head_rvc && stat_i_count != 32'hffff_ffff)
                stat_i_count <= stat_i_count + 32'h1;
        end
    end
`endif

    a_resp_in_flight: assert property (@(posedge clk) disable iff (!reset_n)
        fetch_resp_valid |-> state != S_REQ);

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Scoreboarded bench for rvc_fetch_aligner: directed streams, redirects, resets and a random mix.
module tb_rvc_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_req_valid;
    logic [31:0] fetch_req_addr;
    logic        fetch_req_ready;
    logic        fetch_resp_valid;
    logic [31:0] fetch_resp_data;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_compressed;
    logic        instr_ready = 1'b0;
`ifdef RVC_ALIGNER_STATS_EN
    logic [31:0] stat_c_count, stat_i_count;
`endif

    always #5 clk = ~clk;

    rvc_fetch_aligner #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_addr   (fetch_req_addr),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_data  (fetch_resp_data),
        .instr_valid      (instr_valid),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed),
        .instr_ready      (instr_ready)
`ifdef RVC_ALIGNER_STATS_EN
        ,
        .stat_c_count     (stat_c_count),
        .stat_i_count     (stat_i_count)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        c;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] imem [0:255];
    bit          imem_rand = 1'b0;
    int          resp_dly_fix = 0;
    int          req_cnt = 0;

    // IMEM model: one outstanding read, response after a programmable delay.
    initial begin
        bit          hs, pend;
        logic [31:0] ha, pend_addr;
        int          pend_dly;
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b0;
        fetch_resp_data  = 32'h0;
        pend = 1'b0; pend_dly = 0; pend_addr = 32'h0;
        forever begin
            @(negedge clk);
            hs = reset_n && fetch_req_valid && fetch_req_ready;
            ha = fetch_req_addr;
            @(posedge clk); #1;
            fetch_resp_valid = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend      = 1'b1;
                    pend_addr = ha;
                    pend_dly  = imem_rand ? int'($urandom_range(0, 3)) : resp_dly_fix;
                    req_cnt++;
                end
                if (pend) begin
                    if (pend_dly == 0) begin
                        fetch_resp_valid = 1'b1;
                        fetch_resp_data  = imem[pend_addr[9:2]];
                        pend = 1'b0;
                    end else begin
                        pend_dly--;
                    end
                end
            end
            fetch_req_ready = imem_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: every accepted instruction is checked against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && instr_valid && instr_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_instr pc=%h data=%h c=%0d (none expected)",
                             instr_pc, instr_data, instr_compressed);
                end else begin
                    e = sb.pop_front();
                    if (instr_pc !== e.pc || instr_data !== e.data || instr_compressed !== e.c) begin
                        fails++;
                        $display("FAIL instr got pc=%h data=%h c=%0d expected pc=%h data=%h c=%0d",
                                 instr_pc, instr_data, instr_compressed, e.pc, e.data, e.c);
                    end
                end
            end
        end
    end

    task automatic slot();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] data, input logic c);
        exp_t e;
        e.pc = pc; e.data = data; e.c = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        slot(); slot();
        chk("rst_fetch_req_valid", 32'(fetch_req_valid), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr_compressed", 32'(instr_compressed), 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic load_base();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[0] = 32'h05934529;
        imem[1] = 32'h952e0140;
        imem[2] = 32'h00c00613;
        imem[3] = 32'h90029532;
    endtask

    task automatic expect_base_from6();
        expect_instr(32'h6, 32'h0000952e, 1'b1);
        expect_instr(32'h8, 32'h00c00613, 1'b0);
        expect_instr(32'hc, 32'h00009532, 1'b1);
        expect_instr(32'he, 32'h00009002, 1'b1);
    endtask

    task automatic expect_base();
        expect_instr(32'h0, 32'h00004529, 1'b1);
        expect_instr(32'h2, 32'h01400593, 1'b0);
        expect_base_from6();
    endtask

    // Consumer: ready while expectations remain; optionally hold at PC 0x2 for 5 valid cycles.
    task automatic drain(input int budget, input bit rnd_rdy, input bit hold_en);
        int n = 0;
        int hold = 0;
        while (sb.size() > 0 && n < budget) begin
            if (hold_en && instr_pc == 32'h2 && hold < 5) begin
                instr_ready = 1'b0;
                if (instr_valid) begin
                    hold++;
                    chk("hold_pc", instr_pc, 32'h2);
                    chk("hold_data", instr_data, 32'h01400593);
                    chk("hold_no_fetch", 32'(fetch_req_valid), 32'h0);
                end
            end else begin
                instr_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            slot();
            n++;
        end
        instr_ready = 1'b0;
        if (sb.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout remaining=%0d", sb.size());
            sb.delete();
        end
        if (hold_en) chk("hold_cycles", 32'(hold), 32'd5);
    endtask

    task automatic wait_hs(input int budget);
        int c0 = req_cnt;
        int n = 0;
        while (req_cnt == c0 && n < budget) begin slot(); n++; end
        if (req_cnt == c0) begin
            tests++; fails++;
            $display("FAIL wait_fetch_handshake timeout after %0d cycles", budget);
        end
    endtask

    task automatic wait_resp(input int budget);
        int n = 0;
        while (!fetch_resp_valid && n < budget) begin slot(); n++; end
        if (!fetch_resp_valid) begin
            tests++; fails++;
            $display("FAIL wait_fetch_response timeout after %0d cycles", budget);
        end
    endtask

    initial begin
        logic [15:0] hws[$];
        logic [15:0] lo;
        logic [31:0] w, pc;

        slot();
        load_base();

        // 1: aligned/straddling stream at full rate
        imem_rand = 1'b0; resp_dly_fix = 0;
        do_reset();
        expect_base();
        drain(200, 1'b0, 1'b0);

        // 2: consumer stalls on the straddling instruction
        do_reset();
        expect_base();
        drain(200, 1'b0, 1'b1);

        // 3: redirect while a fetch is outstanding
        resp_dly_fix = 3;
        do_reset();
        wait_hs(20);
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        slot();
        redirect_valid = 1'b0;
        expect_base_from6();
        drain(200, 1'b0, 1'b0);

        // 4: redirect coinciding with a response
        resp_dly_fix = 1;
        do_reset();
        wait_resp(20);
        redirect_valid = 1'b1; redirect_pc = 32'h3;
        slot();
        redirect_valid = 1'b0;
        expect_instr(32'h2, 32'h01400593, 1'b0);
        expect_base_from6();
        drain(200, 1'b0, 1'b0);

        // 6: reset in the middle of an outstanding fetch, then refetch from the reset vector
        resp_dly_fix = 3;
        do_reset();
        wait_hs(20);
        do_reset();
        resp_dly_fix = 0;
        expect_base();
        drain(200, 1'b0, 1'b0);

        // 5: 200 words of random 16/32-bit mix with random IMEM timing and consumer stalls
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        pc = 32'h0;
        while (hws.size() < 400) begin
            if ($urandom_range(0, 1) == 1) begin
                lo = 16'($urandom);
                if (lo[1:0] == 2'b11) lo[1:0] = 2'b01;
                expect_instr(pc, {16'h0, lo}, 1'b1);
                hws.push_back(lo);
                pc += 32'd2;
            end else begin
                w = $urandom;
                w[1:0] = 2'b11;
                expect_instr(pc, w, 1'b0);
                hws.push_back(w[15:0]);
                hws.push_back(w[31:16]);
                pc += 32'd4;
            end
        end
        if (hws.size() % 2 == 1) hws.push_back(16'h0001);
        for (int i = 0; i < hws.size() / 2; i++) imem[i] = {hws[2*i+1], hws[2*i]};
        imem_rand = 1'b1;
        do_reset();
        drain(6000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
